// File: rtl/decimal_keypad_encoder_pkg.sv
// Shared types and helpers for the decimal keypad encoder.
//   kp_state_t      : FSM state encoding (IDLE/DEBOUNCE/EMIT/RELEASE)
//   BCD_W, KEYS     : code width and number of decimal key lines
//   onehot10_to_bcd : index of the set bit in a one-hot key vector
//   is_onehot10     : true when exactly one key bit is set
package decimal_keypad_pkg;

   localparam int BCD_W = 4;
   localparam int KEYS  = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      EMIT     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   // OR of the indices of all set bits; exact for a one-hot input.
   function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [KEYS-1:0] oh);
      logic [BCD_W-1:0] r;
      r = '0;
      for (int i = 0; i < KEYS; i++)
         if (oh[i]) r = r | BCD_W'(i);
      return r;
   endfunction

   // Non-zero with no second bit: clearing the lowest set bit leaves zero.
   function automatic logic is_onehot10(input logic [KEYS-1:0] oh);
      return (oh != '0) && ((oh & (oh - KEYS'(1))) == '0);
   endfunction

endpackage

// File: rtl/decimal_keypad_encoder_if.sv
// Keypad/consumer signal bundle for the decimal keypad encoder.
//   enable, key, ready : driven by the keypad/consumer side (master)
//   bcd, valid         : delivered code and its handshake flag (slave)
//   multi_err          : one-cycle pulse on a multi-key press (slave)
interface decimal_keypad_encoder_if;
   import decimal_keypad_pkg::*;

   logic             enable;
   logic [KEYS-1:0]  key;
   logic             ready;
   logic [BCD_W-1:0] bcd;
   logic             valid;
   logic             multi_err;

   modport master (output enable, key, ready, input bcd, valid, multi_err);
   modport slave  (input enable, key, ready, output bcd, valid, multi_err);

endinterface

// File: rtl/decimal_keypad_encoder_sync_2ff.sv
// Width-parameterised two-flop synchroniser, async active-low reset.
//   clk, rst_n : clock and reset
//   d          : asynchronous input bits
//   q          : synchronised output bits (two cycles of latency)
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/decimal_keypad_encoder.sv
// Decimal keypad to BCD encoder with debounce and valid/ready delivery.
//   clk, rst_n : clock and async active-low reset
//   kp         : slave side of the keypad interface (enable, key, ready in;
//                bcd, valid, multi_err out)
// A single debounced key press yields exactly one code; the FSM then waits
// for DEBOUNCE_CYCLES all-zero cycles before arming again.
module decimal_keypad_encoder
   import decimal_keypad_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   decimal_keypad_encoder_if.slave   kp
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   kp_state_t        state_q, state_d;
   logic [KEYS-1:0]  ksync, kcap_q, kcap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic key_any, key_one, hold_ok, cnt_last;

   sync_2ff #(.W(KEYS)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (kp.key),
      .q     (ksync)
   );

   assign key_any  = (ksync != '0);
   assign key_one  = is_onehot10(ksync);
   assign hold_ok  = (ksync == kcap_q) && kp.enable;
   assign cnt_last = (cnt_q == CNT_LAST);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kcap_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kcap_q  <= kcap_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (kp.enable && key_any) state_d = key_one ? DEBOUNCE : RELEASE;
         DEBOUNCE: if (!hold_ok)             state_d = IDLE;
                   else if (cnt_last)        state_d = EMIT;
         // valid is always high here; enable and key are deliberately ignored
         EMIT:     if (kp.ready)             state_d = RELEASE;
         RELEASE:  if (!key_any && cnt_last) state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // Datapath / output loads
   always_comb begin
      kcap_d  = kcap_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: if (kp.enable && key_any) begin
            cnt_d = '0;
            if (key_one) kcap_d = ksync;
            else         err_d  = 1'b1;
         end
         DEBOUNCE: if (hold_ok) begin
            if (cnt_last) begin
               bcd_d   = onehot10_to_bcd(kcap_q);
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         EMIT: if (kp.ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
         end
         // Any key activity restarts the release quiet-period count.
         RELEASE: cnt_d = key_any ? '0 : cnt_q + CNT_W'(1);
         default: ;
      endcase
   end

   assign kp.bcd       = bcd_q;
   assign kp.valid     = valid_q;
   assign kp.multi_err = err_q;

endmodule

// File: tb/tb_decimal_keypad_encoder.sv
// Self-checking bench for decimal_keypad_encoder: directed scenarios plus
// randomized key/enable/ready traffic, compared every cycle against a
// run-length based behavioural model.
module tb_decimal_keypad_encoder;
   import decimal_keypad_pkg::*;

   localparam int DC = 4;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   decimal_keypad_encoder_if kp_if ();

   decimal_keypad_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, expected summary before it");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Key history gives the synchronised view; 'run' counts consecutive edges
   // a candidate key was seen with enable high, 'zrun' counts quiet edges.
   logic [KEYS-1:0]  kh1, kh2, cand;
   int               mode;   // 0 scanning, 1 code pending, 2 awaiting release
   int               run, zrun;
   logic             m_valid, m_err;
   logic [BCD_W-1:0] m_bcd;

   task automatic model_reset();
      kh1 = '0; kh2 = '0; cand = '0;
      mode = 0; run = 0; zrun = 0;
      m_valid = 1'b0; m_err = 1'b0; m_bcd = '0;
   endtask

   task automatic model_edge(input logic [KEYS-1:0] k, input logic en, input logic rdy);
      logic [KEYS-1:0] ks;
      ks  = kh2;
      kh2 = kh1;
      kh1 = k;
      m_err = 1'b0;
      case (mode)
         0: begin
            if (run > 0) begin
               if (en && ks == cand) begin
                  run++;
                  if (run == DC + 1) begin
                     m_valid = 1'b1;
                     for (int i = 0; i < KEYS; i++) if (cand[i]) m_bcd = BCD_W'(i);
                     mode = 1;
                     run  = 0;
                  end
               end else begin
                  run = 0;
               end
            end else if (en && $countones(ks) == 1) begin
               cand = ks;
               run  = 1;
            end else if (en && $countones(ks) >= 2) begin
               m_err = 1'b1;
               mode  = 2;
               zrun  = 0;
            end
         end
         1: if (rdy) begin
            m_valid = 1'b0;
            mode    = 2;
            zrun    = 0;
         end
         default: begin
            if (ks == '0) begin
               zrun++;
               if (zrun == DC) mode = 0;
            end else begin
               zrun = 0;
            end
         end
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int   edge_no, base, first_vld, pulses, err_cnt;
   logic last_v;
   logic [BCD_W-1:0] vbcd;

   task automatic window();
      first_vld = -1; pulses = 0; err_cnt = 0; vbcd = '0; base = edge_no;
   endtask

   task automatic step();
      logic [KEYS-1:0] k;
      logic en, rdy;
      k = kp_if.key; en = kp_if.enable; rdy = kp_if.ready;
      @(posedge clk);
      model_edge(k, en, rdy);
      edge_no++;
      #1;
      chk("valid", kp_if.valid, m_valid);
      chk("bcd", kp_if.bcd, m_bcd);
      chk("multi_err", kp_if.multi_err, m_err);
      if (kp_if.valid && !last_v) begin
         pulses++;
         if (first_vld < 0) begin
            first_vld = edge_no;
            vbcd      = kp_if.bcd;
         end
      end
      if (kp_if.multi_err) err_cnt++;
      last_v = kp_if.valid;
   endtask

   task automatic idle(input int n);
      kp_if.key = '0;
      repeat (n) step();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      kp_if.key = '0; kp_if.enable = 1'b1; kp_if.ready = 1'b1;
      #1;
      model_reset();
      last_v = 1'b0;
      chk("rst_valid", kp_if.valid, 0);
      chk("rst_bcd", kp_if.bcd, 0);
      chk("rst_multi_err", kp_if.multi_err, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      edge_no = 0;
      window();
      apply_reset();

      // Clean press: one pulse at edge 7 with bcd 5, no repeat while held
      idle(8);
      kp_if.key = 10'b00_0010_0000;
      window();
      repeat (20) step();
      chk("clean_latency", first_vld - base, 7);
      chk("clean_pulses", pulses, 1);
      chk("clean_bcd", vbcd, 5);
      idle(8);
      kp_if.key = 10'b00_0010_0000;
      window();
      repeat (12) step();
      chk("clean_repress_pulses", pulses, 1);

      // Bounce on key[3]
      idle(10);
      window();
      for (int i = 0; i < 4; i++) begin
         kp_if.key = (i % 2 == 0) ? 10'b00_0000_1000 : '0;
         step();
      end
      kp_if.key = 10'b00_0000_1000;
      base = edge_no;
      repeat (15) step();
      chk("bounce_latency", first_vld - base, 7);
      chk("bounce_pulses", pulses, 1);
      chk("bounce_bcd", vbcd, 3);

      // Backpressure on key[9]
      idle(10);
      kp_if.ready = 1'b0;
      kp_if.key   = 10'b10_0000_0000;
      window();
      repeat (8) step();
      chk("bp_valid_seen", pulses, 1);
      kp_if.key = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold_valid", kp_if.valid, 1);
         chk("bp_hold_bcd", kp_if.bcd, 9);
      end
      kp_if.ready = 1'b1;
      step();
      chk("bp_release_valid", kp_if.valid, 0);

      // Multi-key press
      idle(10);
      kp_if.key = 10'b00_0001_0001;
      window();
      repeat (3) step();
      idle(8);
      chk("multi_err_cycles", err_cnt, 1);
      chk("multi_no_valid", pulses, 0);
      kp_if.key = 10'b00_0000_0001;
      window();
      repeat (10) step();
      chk("multi_then_key0", pulses, 1);
      chk("multi_key0_bcd", vbcd, 0);

      // Enable gating on key[2]
      idle(10);
      kp_if.enable = 1'b0;
      kp_if.key    = 10'b00_0000_0100;
      window();
      repeat (15) step();
      chk("gated_no_valid", pulses, 0);
      kp_if.ready  = 1'b0;
      kp_if.enable = 1'b1;
      window();
      repeat (8) step();
      chk("enable_latency", first_vld - base, DC + 1);
      chk("enable_bcd", vbcd, 2);
      kp_if.enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("emit_enable_low", kp_if.valid, 1);
      end
      kp_if.ready = 1'b1;
      step();
      kp_if.enable = 1'b1;
      idle(10);

      // Reset mid-handshake with bcd 7 pending
      kp_if.ready = 1'b0;
      kp_if.key   = 10'b00_1000_0000;
      repeat (8) step();
      chk("pre_rst_valid", kp_if.valid, 1);
      chk("pre_rst_bcd", kp_if.bcd, 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", kp_if.valid, 0);
      chk("async_rst_bcd", kp_if.bcd, 0);
      model_reset();
      last_v    = 1'b0;
      kp_if.key = '0;
      @(negedge clk);
      rst_n       = 1'b1;
      kp_if.ready = 1'b1;
      window();
      repeat (10) step();
      chk("post_rst_no_stale", pulses, 0);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6)      kp_if.key = KEYS'(1) << $urandom_range(0, KEYS - 1);
         else if (r < 8) kp_if.key = '0;
         else            kp_if.key = KEYS'($urandom_range(0, 1023));
         kp_if.enable = ($urandom_range(0, 7) != 0);
         kp_if.ready  = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 10)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
